argmax_stream: RTL

Streaming, parametrised argmax classifier. It accepts a vector of NUM_CLASSES class scores over a valid/ready stream, LANES scores per beat, and keeps a running maximum and its index. When a full vector has arrived, it presents the winning class index and score on a valid/ready output. It sits after the final dense layer of the network and replaces the fixed 10×8-bit combinational classifier, adding signed scores, back-pressure and a deterministic tie rule.

---
 rtl/argmax_pkg.sv | 30 +++
 rtl/argmax_lane_tree.sv | 56 +++++
 rtl/argmax_stream.sv | 116 +++++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax classifier.
package argmax_pkg;

  localparam int unsigned CMP_W           = 64;
  localparam int unsigned DEF_NUM_CLASSES = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IDX_W_CALC = clog2_min1(DEF_NUM_CLASSES);

  // Operands arrive zero-extended; flipping the sign bit maps two's complement
  // ordering onto unsigned ordering.
  function automatic logic cmp_gt(input logic              is_signed,
                                  input logic [CMP_W-1:0]  a,
                                  input logic [CMP_W-1:0]  b,
                                  input int unsigned       w);
    logic [CMP_W-1:0] flip;
    flip = '0;
    if (is_signed) flip[w-1] = 1'b1;
    return (a ^ flip) > (b ^ flip);
  endfunction

endpackage

// File: rtl/argmax_lane_tree.sv
// Combinational max-reduction of one beat of LANES scores; lower lane wins ties.
module argmax_lane_tree
  import argmax_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 8,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned LIDX_W = clog2_min1(LANES)
) (
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic [DATA_W-1:0]       o_max,
  output logic [LIDX_W-1:0]       o_lane
);

  localparam int unsigned LEAVES = 1 << $clog2(LANES);
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  logic [DATA_W-1:0] w_score [NODES];
  logic [LIDX_W-1:0] w_idx   [NODES];
  logic              w_vld   [NODES];

  // Heap layout: node n has children 2n+1 (lower lanes) and 2n+2; padded leaves stay invalid.
  always_comb begin
    int unsigned n;
    int unsigned lc;
    int unsigned rc;
    for (int unsigned k = 0; k < NODES; k++) begin
      w_score[k] = '0;
      w_idx[k]   = '0;
      w_vld[k]   = 1'b0;
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      w_score[LEAVES-1+l] = i_data[l*DATA_W +: DATA_W];
      w_idx[LEAVES-1+l]   = LIDX_W'(l);
      w_vld[LEAVES-1+l]   = 1'b1;
    end
    for (int unsigned k = 0; k + 1 < LEAVES; k++) begin
      n  = LEAVES - 2 - k;
      lc = 2 * n + 1;
      rc = 2 * n + 2;
      if (w_vld[rc] &&
          cmp_gt(SIGNED, CMP_W'(w_score[rc]), CMP_W'(w_score[lc]), DATA_W)) begin
        w_score[n] = w_score[rc];
        w_idx[n]   = w_idx[rc];
      end else begin
        w_score[n] = w_score[lc];
        w_idx[n]   = w_idx[lc];
      end
      w_vld[n] = w_vld[lc] | w_vld[rc];
    end
  end

  assign o_max  = w_score[0];
  assign o_lane = w_idx[0];

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: merges LANES scores per beat into a running best and
// presents the winning class on a valid/ready output once per vector.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LANES       = 2,
  parameter int unsigned DATA_W      = 8,
  parameter bit          SIGNED      = 1'b0,
  parameter int unsigned IDX_W       = clog2_min1(NUM_CLASSES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_index,
  output logic [DATA_W-1:0]       out_score
);

  localparam int unsigned NUM_BEATS = NUM_CLASSES / LANES;
  localparam int unsigned CNT_W     = clog2_min1(NUM_BEATS);
  localparam int unsigned LIDX_W    = clog2_min1(LANES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [DATA_W-1:0] r_best_score;
  logic [IDX_W-1:0]  r_best_idx;
  logic [IDX_W-1:0]  r_out_index;
  logic [DATA_W-1:0] r_out_score;

  logic [DATA_W-1:0] w_beat_max;
  logic [LIDX_W-1:0] w_beat_lane;
  logic [IDX_W-1:0]  w_beat_idx;
  logic              w_accept;
  logic              w_last_beat;
  logic              w_take_beat;
  logic [DATA_W-1:0] w_merge_score;
  logic [IDX_W-1:0]  w_merge_idx;

  argmax_lane_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .SIGNED (SIGNED),
    .LIDX_W (LIDX_W)
  ) u_lane_tree (
    .i_data (in_data),
    .o_max  (w_beat_max),
    .o_lane (w_beat_lane)
  );

  assign w_beat_idx  = IDX_W'(r_beat_cnt) * IDX_W'(LANES) + IDX_W'(w_beat_lane);
  assign w_last_beat = (r_beat_cnt == CNT_W'(NUM_BEATS - 1));
  assign w_accept    = in_valid && in_ready && !flush;

  // Running best already holds a lower index, so only a strictly greater beat replaces it.
  always_comb begin
    w_take_beat   = (r_beat_cnt == '0) ||
                    cmp_gt(SIGNED, CMP_W'(w_beat_max), CMP_W'(r_best_score), DATA_W);
    w_merge_score = w_take_beat ? w_beat_max : r_best_score;
    w_merge_idx   = w_take_beat ? w_beat_idx : r_best_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last_beat) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
    if (flush) w_state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt   <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_out_index  <= '0;
      r_out_score  <= '0;
    end else if (flush) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_best_score <= w_merge_score;
      r_best_idx   <= w_merge_idx;
      if (w_last_beat) begin
        r_beat_cnt  <= '0;
        r_out_index <= w_merge_idx;
        r_out_score <= w_merge_score;
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign out_index = r_out_index;
  assign out_score = r_out_score;

endmodule
